bilinear_pixel_fetch: RTL

- Read side of the scale-down frame buffer.
- Takes each output-pixel request (`coordinate_x`/`coordinate_y` plus four bilinear coefficients) from `vin_vout_ctrl`.
- Issues four reads to the frame-buffer memory port for the 2×2 neighbourhood, then presents the four neighbour pixels and the matching coefficients to `bilinear_calculation` under a valid/ready handshake.
- Memory addresses use the same `{y[15:0], (x<<2)[15:0]}` layout the write path uses.

---
 rtl/bilinear_pixel_fetch_if.sv | 64 ++++++
 rtl/bilinear_pixel_fetch.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bilinear_pixel_fetch_if.sv
// ----------------------------------------------------------------------------
// bilinear_pixel_fetch_if
// Bundles the three buses of the bilinear read-side fetcher:
//   request   : coo_valid/coo_ready, coordinate_x/y, coefficient1..4
//   memory    : rd_en, rd_addr, rd_dat (rd_dat valid one cycle after rd_en)
//   neighbour : pix_valid/pix_ready, doutbx/doutbx1/doutby/doutby1, coef1_o..coef4_o
// Modports:
//   slave  - the fetcher itself (accepts requests, drives memory/neighbour side)
//   master - the environment around it (request source, memory, consumer)
// ----------------------------------------------------------------------------
interface bilinear_pixel_fetch_if #(
    parameter int DW     = 16,
    parameter int CW     = 16,
    parameter int COEF_W = 17,
    parameter int AW     = 2 * CW
);
    logic              coo_valid;
    logic              coo_ready;
    logic [CW-1:0]     coordinate_x;
    logic [CW-1:0]     coordinate_y;
    logic [COEF_W-1:0] coefficient1;
    logic [COEF_W-1:0] coefficient2;
    logic [COEF_W-1:0] coefficient3;
    logic [COEF_W-1:0] coefficient4;

    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     rd_dat;

    logic              pix_valid;
    logic              pix_ready;
    logic [DW-1:0]     doutbx;
    logic [DW-1:0]     doutbx1;
    logic [DW-1:0]     doutby;
    logic [DW-1:0]     doutby1;
    logic [COEF_W-1:0] coef1_o;
    logic [COEF_W-1:0] coef2_o;
    logic [COEF_W-1:0] coef3_o;
    logic [COEF_W-1:0] coef4_o;

    modport slave (
        input  coo_valid, coordinate_x, coordinate_y,
               coefficient1, coefficient2, coefficient3, coefficient4,
        output coo_ready,
        output rd_en, rd_addr,
        input  rd_dat,
        output pix_valid,
        input  pix_ready,
        output doutbx, doutbx1, doutby, doutby1,
               coef1_o, coef2_o, coef3_o, coef4_o
    );

    modport master (
        output coo_valid, coordinate_x, coordinate_y,
               coefficient1, coefficient2, coefficient3, coefficient4,
        input  coo_ready,
        input  rd_en, rd_addr,
        output rd_dat,
        input  pix_valid,
        output pix_ready,
        input  doutbx, doutbx1, doutby, doutby1,
               coef1_o, coef2_o, coef3_o, coef4_o
    );
endinterface

// File: rtl/bilinear_pixel_fetch.sv
// ----------------------------------------------------------------------------
// bilinear_pixel_fetch
// Read side of the scale-down frame buffer. Accepts one output-pixel request
// (top-left neighbour coordinate + four bilinear weights), reads the 2x2
// neighbourhood from the frame-buffer memory port and hands the four pixels
// plus the weights to the bilinear calculation stage.
//
// Ports:
//   vin_clk            clock, rising edge
//   rst                asynchronous active-high reset
//   frame_sync_n       low = flush to IDLE and hold off new requests
//   vin_xres/vin_yres  source frame size (each >= 2)
//   bus (slave)        request, memory and neighbour buses
//
// Optional feature: BILINEAR_FETCH_CLAMP_EN
//   defined   - x, x+1 clamped to vin_xres-1 and y, y+1 to vin_yres-1
//               (edge pixels replicated)
//   undefined - raw x, x+1, y, y+1; upstream keeps x <= xres-2, y <= yres-2
//
// State table:
//   state | meaning
//   IDLE  | waiting for a request
//   RD0   | read (x ,y )
//   RD1   | read (x1,y ), capture pixel (x ,y )
//   RD2   | read (x ,y1), capture pixel (x1,y )
//   RD3   | read (x1,y1), capture pixel (x ,y1)
//   CAP   | capture pixel (x1,y1)
//   OUT   | neighbourhood presented (pix_valid)
// ----------------------------------------------------------------------------
module bilinear_pixel_fetch #(
    parameter int DW     = 16,
    parameter int CW     = 16,
    parameter int COEF_W = 17,
    parameter int AW     = 2 * CW
) (
    input  logic            vin_clk,
    input  logic            rst,
    input  logic            frame_sync_n,
    input  logic [CW-1:0]   vin_xres,
    input  logic [CW-1:0]   vin_yres,
    bilinear_pixel_fetch_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_CAP, S_OUT
    } state_t;

    state_t state, state_nx;

    logic              coo_ready_c;
    logic              rd_en_c;
    logic [AW-1:0]     addr_c;
    logic              pix_valid_c;
    logic              accept;

    logic [CW-1:0]     x0_n, x1_n, y0_n, y1_n;
    logic [CW-1:0]     x0_q, x1_q, y0_q, y1_q;
    logic [COEF_W-1:0] coef_q [4];
    logic [DW-1:0]     pix_q  [4];

    assign accept = bus.coo_valid && coo_ready_c;

    // Neighbour coordinates, resolved at acceptance time.
`ifdef BILINEAR_FETCH_CLAMP_EN
    logic [CW-1:0] x_max, y_max;
    logic [CW:0]   x_inc, y_inc;

    always_comb begin
        x_max = vin_xres - CW'(1);
        y_max = vin_yres - CW'(1);
        // one extra bit so x+1 at the top of the range still compares correctly
        x_inc = {1'b0, bus.coordinate_x} + (CW+1)'(1);
        y_inc = {1'b0, bus.coordinate_y} + (CW+1)'(1);
        x0_n  = (bus.coordinate_x > x_max) ? x_max : bus.coordinate_x;
        y0_n  = (bus.coordinate_y > y_max) ? y_max : bus.coordinate_y;
        x1_n  = (x_inc > {1'b0, x_max}) ? x_max : x_inc[CW-1:0];
        y1_n  = (y_inc > {1'b0, y_max}) ? y_max : y_inc[CW-1:0];
    end
`else
    // Frame size only matters when clamping.
    logic unused_res;
    assign unused_res = ^{vin_xres, vin_yres};

    always_comb begin
        x0_n = bus.coordinate_x;
        y0_n = bus.coordinate_y;
        x1_n = bus.coordinate_x + CW'(1);
        y1_n = bus.coordinate_y + CW'(1);
    end
`endif

    // State register
    always_ff @(posedge vin_clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; a flush overrides everything, including a handshake.
    always_comb begin
        state_nx = state;
        if (!frame_sync_n) begin
            state_nx = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (accept) state_nx = S_RD0;
                S_RD0:   state_nx = S_RD1;
                S_RD1:   state_nx = S_RD2;
                S_RD2:   state_nx = S_RD3;
                S_RD3:   state_nx = S_CAP;
                S_CAP:   state_nx = S_OUT;
                S_OUT:   if (bus.pix_ready) state_nx = accept ? S_RD0 : S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        coo_ready_c = frame_sync_n &&
                      ((state == S_IDLE) || ((state == S_OUT) && bus.pix_ready));
        pix_valid_c = (state == S_OUT);
        rd_en_c     = 1'b0;
        addr_c      = {y0_q, x0_q[CW-3:0], 2'b00};
        unique case (state)
            S_RD0: rd_en_c = 1'b1;
            S_RD1: begin
                rd_en_c = 1'b1;
                addr_c  = {y0_q, x1_q[CW-3:0], 2'b00};
            end
            S_RD2: begin
                rd_en_c = 1'b1;
                addr_c  = {y1_q, x0_q[CW-3:0], 2'b00};
            end
            S_RD3: begin
                rd_en_c = 1'b1;
                addr_c  = {y1_q, x1_q[CW-3:0], 2'b00};
            end
            default: ;
        endcase
    end

    // Request capture and pixel capture. Read data arrives one cycle after
    // its strobe, so each pixel lands in the state after its read.
    always_ff @(posedge vin_clk or posedge rst) begin
        if (rst) begin
            x0_q <= '0;
            x1_q <= '0;
            y0_q <= '0;
            y1_q <= '0;
            for (int i = 0; i < 4; i++) begin
                coef_q[i] <= '0;
                pix_q[i]  <= '0;
            end
        end else begin
            if (accept) begin
                x0_q      <= x0_n;
                x1_q      <= x1_n;
                y0_q      <= y0_n;
                y1_q      <= y1_n;
                coef_q[0] <= bus.coefficient1;
                coef_q[1] <= bus.coefficient2;
                coef_q[2] <= bus.coefficient3;
                coef_q[3] <= bus.coefficient4;
            end
            if (frame_sync_n) begin
                unique case (state)
                    S_RD1:   pix_q[0] <= bus.rd_dat;
                    S_RD2:   pix_q[1] <= bus.rd_dat;
                    S_RD3:   pix_q[2] <= bus.rd_dat;
                    S_CAP:   pix_q[3] <= bus.rd_dat;
                    default: ;
                endcase
            end
        end
    end

    assign bus.coo_ready = coo_ready_c;
    assign bus.rd_en     = rd_en_c;
    assign bus.rd_addr   = addr_c;
    assign bus.pix_valid = pix_valid_c;
    assign bus.doutbx    = pix_q[0];
    assign bus.doutbx1   = pix_q[1];
    assign bus.doutby    = pix_q[2];
    assign bus.doutby1   = pix_q[3];
    assign bus.coef1_o   = coef_q[0];
    assign bus.coef2_o   = coef_q[1];
    assign bus.coef3_o   = coef_q[2];
    assign bus.coef4_o   = coef_q[3];

endmodule
